// File: rtl/mc_control_if.sv
// Bundle of the multicycle controller's datapath-facing signals.
// master: the controller (consumes datapath status, drives controls).
// slave:  the datapath / instruction register side.
interface mc_control_if;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        MemReady;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCEn;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        IRWrite;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;

    logic [3:0]  State;
    logic        IllegalOp;
    logic [15:0] Retired;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, State, IllegalOp, Retired
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, State, IllegalOp, Retired
    );
endinterface

// File: rtl/mc_control.sv
// Moore-style control FSM for a multicycle MIPS subset (lw, sw, R-type,
// beq, j, addi) with a memory-ready handshake and a retired-instruction
// counter. Only the FETCH write strobes and the DECODE illegal flag look
// at live inputs; everything else is a pure function of the state.
module mc_control (
    input  logic         Clock,
    input  logic         Reset,
    mc_control_if.master bus
);

    localparam logic [3:0] ST_RST     = 4'hF;
    localparam logic [3:0] ST_FETCH   = 4'h0;
    localparam logic [3:0] ST_DECODE  = 4'h1;
    localparam logic [3:0] ST_MEMADR  = 4'h2;
    localparam logic [3:0] ST_MEMRD   = 4'h3;
    localparam logic [3:0] ST_MEMWB   = 4'h4;
    localparam logic [3:0] ST_MEMWR   = 4'h5;
    localparam logic [3:0] ST_EXEC    = 4'h6;
    localparam logic [3:0] ST_RTYPEWB = 4'h7;
    localparam logic [3:0] ST_BRANCH  = 4'h8;
    localparam logic [3:0] ST_JUMP    = 4'h9;
    localparam logic [3:0] ST_ADDIEX  = 4'hA;
    localparam logic [3:0] ST_ADDIWB  = 4'hB;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]  state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;

    // Next-state selection; the opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:     state_d = ST_FETCH;
            ST_FETCH:   state_d = bus.MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (bus.Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   state_d = bus.MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   state_d = ST_FETCH;
            ST_MEMWR:   state_d = bus.MemReady ? ST_FETCH : ST_MEMWR;
            ST_EXEC:    state_d = ST_RTYPEWB;
            ST_RTYPEWB: state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_ADDIWB:  state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_MEMWB, ST_RTYPEWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: retire = 1'b1;
            ST_MEMWR: retire = bus.MemReady;
            default:  retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + 16'd1 : retired_q;
    end

    // State and counter registers; reset parks the FSM in RST with a clear count.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_RST;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Control decode: everything defaults low, each state raises only its own strobes.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.IllegalOp   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            ST_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.Opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: bus.IllegalOp = 1'b0;
                    default: bus.IllegalOp = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            ST_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            ST_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            ST_RTYPEWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            ST_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            ST_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ST_ADDIWB: begin
                bus.RegWrite = 1'b1;
            end
            default: begin
                bus.IllegalOp = 1'b0;
            end
        endcase
    end

    // PC enable merges the unconditional and the zero-qualified branch write.
    assign bus.PCEn    = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
    assign bus.State   = state_q;
    assign bus.Retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and randomized instruction
// streams are compared cycle by cycle against an instruction-level model
// (state path per instruction class, control table per state, retire count).
module tb_mc_control;

    localparam logic [3:0] S_RST     = 4'hF;
    localparam logic [3:0] S_FETCH   = 4'h0;
    localparam logic [3:0] S_DECODE  = 4'h1;
    localparam logic [3:0] S_MEMADR  = 4'h2;
    localparam logic [3:0] S_MEMRD   = 4'h3;
    localparam logic [3:0] S_MEMWB   = 4'h4;
    localparam logic [3:0] S_MEMWR   = 4'h5;
    localparam logic [3:0] S_EXEC    = 4'h6;
    localparam logic [3:0] S_RTYPEWB = 4'h7;
    localparam logic [3:0] S_BRANCH  = 4'h8;
    localparam logic [3:0] S_JUMP    = 4'h9;
    localparam logic [3:0] S_ADDIEX  = 4'hA;
    localparam logic [3:0] S_ADDIWB  = 4'hB;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    logic        Clock;
    logic        Reset;
    int          checks;
    int          errors;
    logic [15:0] model_retired;

    mc_control_if bus ();

    mc_control dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic pick_zero(input int zval);
        if (zval < 0) return 1'($urandom_range(0, 1));
        return 1'(zval);
    endfunction

    // Control strobes each state is documented to raise.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_RTYPEWB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB:  c.reg_write = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obs_ctrl();
        ctrl_t c;
        c.pc_write      = bus.PCWrite;
        c.pc_write_cond = bus.PCWriteCond;
        c.iord          = bus.IorD;
        c.mem_read      = bus.MemRead;
        c.mem_write     = bus.MemWrite;
        c.mem_to_reg    = bus.MemtoReg;
        c.ir_write      = bus.IRWrite;
        c.reg_dst       = bus.RegDst;
        c.reg_write     = bus.RegWrite;
        c.alu_src_a     = bus.ALUSrcA;
        c.alu_src_b     = bus.ALUSrcB;
        c.alu_op        = bus.ALUOp;
        c.pc_source     = bus.PCSource;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then check the state the model expects.
    task automatic applyStimulus(input logic [3:0] exp_state, input logic [5:0] op,
                                 input logic mr, input logic z, input logic exp_illegal);
        ctrl_t e;
        @(negedge Clock);
        bus.Opcode   = op;
        bus.MemReady = mr;
        bus.Zero     = z;
        #1;
        e = exp_ctrl(exp_state, mr);
        checkOutput("state",   32'(bus.State), 32'(exp_state));
        checkOutput("ctrl",    32'(obs_ctrl()), 32'(e));
        checkOutput("pcen",    32'(bus.PCEn), 32'(e.pc_write | (e.pc_write_cond & z)));
        checkOutput("illegal", 32'(bus.IllegalOp), 32'(exp_illegal));
        checkOutput("retired", 32'(bus.Retired), 32'(model_retired));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_state"},   32'(bus.State), 32'(S_RST));
        checkOutput({tag, "_ctrl"},    32'(obs_ctrl()), 32'(0));
        checkOutput({tag, "_pcen"},    32'(bus.PCEn), 32'(0));
        checkOutput({tag, "_illegal"}, 32'(bus.IllegalOp), 32'(0));
        checkOutput({tag, "_retired"}, 32'(bus.Retired), 32'(0));
    endtask

    // One whole instruction. waits<0 means random memory stalls, otherwise
    // exactly that many stall cycles in the data-memory state. zval<0 = random Zero.
    task automatic runInstr(input logic [5:0] op, input int waits, input int zval);
        int w;
        logic legal;
        w = (waits < 0) ? $urandom_range(0, 2) : 0;
        for (int i = 0; i < w; i++) applyStimulus(S_FETCH, junk(), 1'b0, pick_zero(zval), 1'b0);
        applyStimulus(S_FETCH, junk(), 1'b1, pick_zero(zval), 1'b0);
        legal = is_legal(op);
        applyStimulus(S_DECODE, op, 1'($urandom_range(0, 1)), pick_zero(zval), !legal);
        if (legal) begin
            w = (waits < 0) ? $urandom_range(0, 3) : waits;
            case (op)
                OP_LW: begin
                    applyStimulus(S_MEMADR, op, 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                    for (int i = 0; i < w; i++) applyStimulus(S_MEMRD, junk(), 1'b0, pick_zero(zval), 1'b0);
                    applyStimulus(S_MEMRD, junk(), 1'b1, pick_zero(zval), 1'b0);
                    applyStimulus(S_MEMWB, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                end
                OP_SW: begin
                    applyStimulus(S_MEMADR, op, 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                    for (int i = 0; i < w; i++) applyStimulus(S_MEMWR, junk(), 1'b0, pick_zero(zval), 1'b0);
                    applyStimulus(S_MEMWR, junk(), 1'b1, pick_zero(zval), 1'b0);
                end
                OP_R: begin
                    applyStimulus(S_EXEC, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                    applyStimulus(S_RTYPEWB, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                end
                OP_BEQ: applyStimulus(S_BRANCH, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                OP_J:   applyStimulus(S_JUMP, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                default: begin
                    applyStimulus(S_ADDIEX, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                    applyStimulus(S_ADDIWB, junk(), 1'($urandom_range(0, 1)), pick_zero(zval), 1'b0);
                end
            endcase
            model_retired = model_retired + 16'd1;
        end
    endtask

    initial begin
        logic [5:0] op;
        checks        = 0;
        errors        = 0;
        model_retired = 16'h0000;
        Reset         = 1'b1;
        bus.Opcode    = 6'b0;
        bus.Zero      = 1'b0;
        bus.MemReady  = 1'b1;

        // Power-on reset acts without a clock edge.
        #2 Reset = 1'b0;
        #1 checkResetState("por");
        @(posedge Clock);
        #2 Reset = 1'b1;
        applyStimulus(S_RST, junk(), 1'b1, 1'b0, 1'b0);

        // Directed instructions.
        runInstr(OP_LW, 0, 0);
        runInstr(OP_SW, 3, 0);
        runInstr(OP_BEQ, 0, 1);
        runInstr(OP_BEQ, 0, 0);
        runInstr(OP_R, 0, -1);
        runInstr(OP_ADDI, 0, -1);
        runInstr(OP_J, 0, -1);
        runInstr(6'b111111, 0, 0);

        // Randomized instruction mix with random stalls.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = junk();
                    if (is_legal(op)) op = 6'b111110;
                end
            endcase
            runInstr(op, -1, -1);
        end

        // Reset in the middle of a stalled load.
        applyStimulus(S_FETCH, junk(), 1'b1, 1'b0, 1'b0);
        applyStimulus(S_DECODE, OP_LW, 1'b1, 1'b0, 1'b0);
        applyStimulus(S_MEMADR, OP_LW, 1'b1, 1'b0, 1'b0);
        applyStimulus(S_MEMRD, junk(), 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        #1 checkResetState("abort_memrd");
        model_retired = 16'h0000;
        @(posedge Clock);
        #2 Reset = 1'b1;

        // Counter wrap: the count is preset to one below FFFF in place of
        // 65534 real jumps, then two jumps take it through FFFF to 0000.
        dut.retired_q = 16'hFFFE;
        model_retired = 16'hFFFE;
        applyStimulus(S_RST, junk(), 1'b1, 1'b0, 1'b0);
        runInstr(OP_J, 0, -1);
        runInstr(OP_J, 0, -1);

        // Reset while a store waits: the write strobe must drop at once and not return.
        applyStimulus(S_FETCH, junk(), 1'b1, 1'b0, 1'b0);
        applyStimulus(S_DECODE, OP_SW, 1'b1, 1'b0, 1'b0);
        applyStimulus(S_MEMADR, OP_SW, 1'b1, 1'b0, 1'b0);
        applyStimulus(S_MEMWR, junk(), 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        #1 checkResetState("abort_memwr");
        model_retired = 16'h0000;
        @(posedge Clock);
        #2 Reset = 1'b1;
        applyStimulus(S_RST, junk(), 1'b0, 1'b0, 1'b0);
        runInstr(OP_LW, -1, -1);
        runInstr(OP_SW, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port: Clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: Opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port: Zero  input  1  ALU zero flag.
REQ-005 SHALL have port: MemReady  input  1  memory handshake; 1 = the current read or write completes this cycle.
REQ-006 SHALL have ports: PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 SHALL have ports: ALUSrcB, ALUOp, PCSource  output  2 each  datapath mux and ALU selects.
REQ-008 SHALL have port: State  output  4  current FSM state, for debug.
REQ-009 SHALL have port: IllegalOp  output  1  unsupported opcode flag.
REQ-010 SHALL have port: Retired  output  16  count of completed instructions.

Function
REQ-011 SHALL implement a Moore FSM with these encodings: RST=F, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=A, ADDIWB=B.
REQ-012 SHALL hold every control output at 0 unless the state description below asserts it.
REQ-013 RST: all controls 0; next state is FETCH unconditionally.
REQ-014 FETCH: MemRead=1, ALUSrcB=01; IRWrite=1 and PCWrite=1 only while MemReady=1; stay in FETCH while MemReady=0, go to DECODE when MemReady=1.
REQ-015 DECODE: ALUSrcB=11; next state by opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDIEX
- any other opcode -> FETCH, with IllegalOp=1 for that DECODE cycle only.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10; lw -> MEMRD, sw -> MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then go to MEMWB.
REQ-018 MEMWB: MemtoReg=1, RegWrite=1; next state FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1, held steady through wait cycles; go to FETCH on MemReady=1.
REQ-020 EXEC: ALUSrcA=1, ALUOp=10; next state RTYPEWB.
REQ-021 RTYPEWB: RegDst=1, RegWrite=1; next state FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10; next state ADDIWB.
REQ-025 ADDIWB: RegWrite=1, RegDst=0; next state FETCH.
REQ-026 PCEn SHALL be combinational: PCWrite | (PCWriteCond & Zero).
REQ-027 Retired SHALL increment by 1 on each edge that leaves MEMWB, RTYPEWB, BRANCH, JUMP or ADDIWB, or leaves MEMWR with MemReady=1.
REQ-028 Retired SHALL wrap from FFFF to 0000; illegal opcodes SHALL NOT increment it.
REQ-029 Opcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-030 Cycle counts with MemReady=1 throughout:
- lw: 5 cycles
- sw, R-type, addi: 4 cycles
- beq, j: 3 cycles.
REQ-031 Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.

Reset
REQ-032 Reset=0 SHALL immediately, without a clock edge, force State=F, all control outputs to 0, IllegalOp=0 and Retired=0000, including in the middle of an instruction or a memory wait.
REQ-033 After Reset returns to 1, the first edge SHALL enter FETCH; no memory write SHALL be issued by a reset-aborted instruction.

Verification
REQ-034 Reset low then high, MemReady=1 -> State F, then 0 on the first edge; all controls 0 while in RST.
REQ-035 lw (100011), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; Retired 0000 -> 0001.
REQ-036 sw with MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1; then FETCH; Retired +1.
REQ-037 beq with Zero=1 -> PCEn=1 in BRANCH; with Zero=0 -> PCEn=0; both return to FETCH after 3 cycles.
REQ-038 Opcode 111111 in DECODE -> IllegalOp=1 for one cycle, next state FETCH, Retired unchanged.
REQ-039 Preload Retired to FFFF via 65535 jumps, then one more j -> Retired=0000; Reset asserted during MEMRD -> State=F and Retired=0000 immediately.
